// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter slice.
package mem_arb_pkg;

    localparam int unsigned DEF_NUM_PORTS  = 2;
    localparam int unsigned DEF_ADDR_WIDTH = 32;
    localparam int unsigned DEF_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } arb_state_t;

    // Index width that stays at least 1 bit so a single-port build still has a legal vector
    function automatic int unsigned port_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping around.
module rr_picker
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS = DEF_NUM_PORTS,
    parameter int unsigned IDX_W     = port_idx_w(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [NUM_PORTS-1:0] grant,
    output logic [IDX_W-1:0]     idx,
    output logic                 any_req
);

    int unsigned          cand;
    logic [NUM_PORTS-1:0] rot;

    always_comb begin
        grant   = '0;
        idx     = '0;
        any_req = 1'b0;
        cand    = 0;
        rot     = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            cand = (32'(ptr) + i) % NUM_PORTS;
            rot  = req >> cand;
            if (!any_req && rot[0]) begin
                any_req = 1'b1;
                idx     = IDX_W'(cand);
                grant   = NUM_PORTS'(1) << cand;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter from NUM_PORTS requesters onto the single memory_* port,
// one transaction in flight, with optional response timeout.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = DEF_NUM_PORTS,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned TIMEOUT    = 0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            req_valid,
    input  logic [NUM_PORTS-1:0]            req_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]            req_ready,
    output logic [NUM_PORTS-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_rdata,
    output logic                            rsp_err,
    output logic [ADDR_WIDTH-1:0]           memory_addr,
    output logic                            memory_rden,
    output logic                            memory_wren,
    input  logic [DATA_WIDTH-1:0]           memory_read_val,
    output logic [DATA_WIDTH-1:0]           memory_write_val,
    input  logic                            memory_response
);

    localparam int unsigned IDX_W = port_idx_w(NUM_PORTS);
    localparam int unsigned TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    arb_state_t            state;
    logic [IDX_W-1:0]      rr_ptr;
    logic [IDX_W-1:0]      idx_q;
    logic                  write_q;
    logic [TO_W-1:0]       to_cnt;

    logic [NUM_PORTS-1:0]  pick_grant;
    logic [IDX_W-1:0]      pick_idx;
    logic                  any_req;
    logic                  sel_write;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  timeout_hit;

    rr_picker #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_picker (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .grant   (pick_grant),
        .idx     (pick_idx),
        .any_req (any_req)
    );

    assign sel_write   = |(req_write & pick_grant);
    assign sel_addr    = ADDR_WIDTH'(req_addr >> (32'(pick_idx) * ADDR_WIDTH));
    assign sel_wdata   = DATA_WIDTH'(req_wdata >> (32'(pick_idx) * DATA_WIDTH));
    assign timeout_hit = (TIMEOUT != 0) && (32'(to_cnt) == TIMEOUT - 1);
    assign req_ready   = (state == IDLE) ? pick_grant : '0;

    // The memory_* outputs double as the latched request, so no separate copy is kept
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            rr_ptr           <= '0;
            idx_q            <= '0;
            write_q          <= 1'b0;
            to_cnt           <= '0;
            memory_addr      <= '0;
            memory_write_val <= '0;
            memory_rden      <= 1'b0;
            memory_wren      <= 1'b0;
            rsp_valid        <= '0;
            rsp_rdata        <= '0;
            rsp_err          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        idx_q            <= pick_idx;
                        write_q          <= sel_write;
                        memory_addr      <= sel_addr;
                        memory_write_val <= sel_wdata;
                        memory_rden      <= !sel_write;
                        memory_wren      <= sel_write;
                        to_cnt           <= '0;
                        rr_ptr           <= (32'(pick_idx) == NUM_PORTS - 1) ? '0 : pick_idx + 1'b1;
                        state            <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (memory_response || timeout_hit) begin
                        rsp_valid        <= NUM_PORTS'(1) << idx_q;
                        rsp_err          <= !memory_response;
                        rsp_rdata        <= (memory_response && !write_q) ? memory_read_val : '0;
                        memory_rden      <= 1'b0;
                        memory_wren      <= 1'b0;
                        memory_addr      <= '0;
                        memory_write_val <= '0;
                        state            <= DONE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                DONE: begin
                    rsp_valid <= '0;
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
                    to_cnt    <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level round-robin model.
module tb_mem_port_arbiter;

    localparam int unsigned NP = 3;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic [NP-1:0]      req_valid;
    logic [NP-1:0]      req_write;
    logic [NP*AW-1:0]   req_addr;
    logic [NP*DW-1:0]   req_wdata;
    logic [NP-1:0]      req_ready;
    logic [NP-1:0]      rsp_valid;
    logic [DW-1:0]      rsp_rdata;
    logic               rsp_err;
    logic [AW-1:0]      memory_addr;
    logic               memory_rden;
    logic               memory_wren;
    logic [DW-1:0]      memory_read_val;
    logic [DW-1:0]      memory_write_val;
    logic               memory_response;

    mem_port_arbiter #(
        .NUM_PORTS  (NP),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TO)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_write        (req_write),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .req_ready        (req_ready),
        .rsp_valid        (rsp_valid),
        .rsp_rdata        (rsp_rdata),
        .rsp_err          (rsp_err),
        .memory_addr      (memory_addr),
        .memory_rden      (memory_rden),
        .memory_wren      (memory_wren),
        .memory_read_val  (memory_read_val),
        .memory_write_val (memory_write_val),
        .memory_response  (memory_response)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Requester-side model: one pending request per port, plus the arbiter's pointer
    bit          pend_v [NP];
    bit          pend_w [NP];
    logic [AW-1:0] pend_a [NP];
    logic [DW-1:0] pend_d [NP];
    int          ptr = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_pick();
        for (int k = 0; k < NP; k++) begin
            int p;
            p = (ptr + k) % NP;
            if (pend_v[p]) return p;
        end
        return -1;
    endfunction

    task automatic drive_reqs();
        for (int i = 0; i < NP; i++) begin
            req_valid[i]            = pend_v[i];
            req_write[i]            = pend_v[i] ? pend_w[i] : 1'($urandom);
            req_addr[i*AW +: AW]    = pend_v[i] ? pend_a[i] : AW'($urandom);
            req_wdata[i*DW +: DW]   = pend_v[i] ? pend_d[i] : DW'($urandom);
        end
    endtask

    task automatic gen_reqs();
        for (int i = 0; i < NP; i++) begin
            if (pend_v[i]) begin
                if ($urandom_range(7) == 0) pend_v[i] = 0;
            end else if ($urandom_range(1) == 1) begin
                pend_v[i] = 1;
                pend_w[i] = 1'($urandom);
                pend_a[i] = AW'($urandom);
                pend_d[i] = DW'($urandom);
            end
        end
    endtask

    task automatic set_req(input int p, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        pend_v[p] = 1;
        pend_w[p] = w;
        pend_a[p] = a;
        pend_d[p] = d;
    endtask

    // One IDLE arbitration cycle and, if a port wins, its full transaction.
    // delay = ACCESS cycle index carrying memory_response; >= TO means no response.
    task automatic serve(input int unsigned delay, input logic [DW-1:0] rdv, input bit gen);
        int            w;
        bit            t_wr;
        logic [AW-1:0] t_a;
        logic [DW-1:0] t_d;
        bit            to;
        int unsigned   last;
        if (gen) gen_reqs();
        drive_reqs();
        memory_response = 1'($urandom);
        memory_read_val = DW'($urandom);
        #1;
        w = model_pick();
        check_eq("req_ready_idle", 64'(req_ready), (w < 0) ? 64'd0 : (64'd1 << w));
        check_eq("rsp_valid_idle", 64'(rsp_valid), 64'd0);
        if (w < 0) begin
            tick();
            return;
        end
        t_wr = pend_w[w];
        t_a  = pend_a[w];
        t_d  = pend_d[w];
        pend_v[w] = 0;
        ptr = (w + 1) % NP;
        tick();
        if (gen) gen_reqs();
        drive_reqs();
        to   = (delay >= TO);
        last = to ? TO - 1 : delay;
        for (int unsigned j = 0; j <= last; j++) begin
            memory_response = (!to && j == last);
            memory_read_val = (j == last) ? rdv : DW'($urandom);
            #1;
            check_eq("memory_rden", 64'(memory_rden), 64'(!t_wr));
            check_eq("memory_wren", 64'(memory_wren), 64'(t_wr));
            check_eq("memory_addr", 64'(memory_addr), 64'(t_a));
            if (t_wr) check_eq("memory_write_val", 64'(memory_write_val), 64'(t_d));
            check_eq("req_ready_busy", 64'(req_ready), 64'd0);
            check_eq("rsp_valid_busy", 64'(rsp_valid), 64'd0);
            tick();
        end
        memory_response = 1'($urandom);
        memory_read_val = DW'($urandom);
        #1;
        check_eq("rsp_valid_done", 64'(rsp_valid), 64'd1 << w);
        check_eq("rsp_err", 64'(rsp_err), 64'(to));
        check_eq("rsp_rdata", 64'(rsp_rdata), (to || t_wr) ? 64'd0 : 64'(rdv));
        check_eq("strobes_done", {62'd0, memory_rden, memory_wren}, 64'd0);
        check_eq("req_ready_done", 64'(req_ready), 64'd0);
        tick();
        check_eq("rsp_valid_after", 64'(rsp_valid), 64'd0);
        check_eq("rsp_err_after", 64'(rsp_err), 64'd0);
    endtask

    initial begin
        int w;
        for (int i = 0; i < NP; i++) pend_v[i] = 0;
        reset = 1'b1;
        memory_response = 1'b0;
        memory_read_val = '0;
        drive_reqs();
        repeat (3) tick();
        check_eq("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("reset_strobes", {62'd0, memory_rden, memory_wren}, 64'd0);
        check_eq("reset_addr", 64'(memory_addr), 64'd0);
        check_eq("reset_rdata", {31'd0, rsp_err, rsp_rdata}, 64'd0);
        reset = 1'b0;
        tick();

        // single read, response on the 3rd strobe cycle
        set_req(0, 1'b0, 32'h0000_0040, 32'h0);
        serve(2, 32'hDEAD_BEEF, 0);
        // write on port1, immediate response; read data must not leak through
        set_req(1, 1'b1, 32'h0000_0100, 32'h1234_5678);
        serve(0, 32'hFFFF_FFFF, 0);
        // all ports continuously requesting: grants rotate
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < NP; i++)
                if (!pend_v[i]) set_req(i, 1'($urandom), AW'($urandom), DW'($urandom));
            serve(0, DW'($urandom), 0);
        end
        // timeout, then response landing exactly on the last allowed cycle
        set_req(2, 1'b0, 32'h0000_0200, 32'h0);
        serve(9, 32'hCAFE_F00D, 0);
        set_req(0, 1'b0, 32'h0000_0300, 32'h0);
        serve(TO - 1, 32'h5A5A_A5A5, 0);
        // randomized traffic
        for (int k = 0; k < 60; k++) serve($urandom_range(TO + 1), DW'($urandom), 1);

        // reset during the 2nd ACCESS cycle of a port1 transaction
        for (int i = 0; i < NP; i++) pend_v[i] = 0;
        set_req(1, 1'b0, 32'h0000_0500, 32'h0);
        drive_reqs();
        memory_response = 1'b0;
        #1;
        w = model_pick();
        check_eq("req_ready_prereset", 64'(req_ready), 64'd1 << w);
        tick();
        pend_v[1] = 0;
        drive_reqs();
        check_eq("rden_prereset", 64'(memory_rden), 64'd1);
        tick();
        reset = 1'b1;
        tick();
        check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("rst_strobes", {62'd0, memory_rden, memory_wren}, 64'd0);
        check_eq("rst_addr", 64'(memory_addr), 64'd0);
        check_eq("rst_wval", 64'(memory_write_val), 64'd0);
        check_eq("rst_rdata_err", {31'd0, rsp_err, rsp_rdata}, 64'd0);
        check_eq("rst_req_ready", 64'(req_ready), 64'd0);
        reset = 1'b0;
        ptr = 0;
        memory_response = 1'b1;
        repeat (2) begin
            tick();
            check_eq("rst_no_rsp", 64'(rsp_valid), 64'd0);
        end
        set_req(0, 1'b0, 32'h0000_0600, 32'h0);
        set_req(1, 1'b0, 32'h0000_0700, 32'h0);
        serve(1, 32'h0BAD_CAFE, 0);
        serve(0, 32'h1111_2222, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Parametrised memory access unit that sits between several core-side requesters (instruction fetch, data load/store, later DMA) and the single memory port of the core.
- The memory port uses the core's existing memory_* handshake.
- It round-robin arbitrates NUM_PORTS requesters and keeps one transaction outstanding at a time.
- It waits any number of cycles for memory_response, with an optional timeout, and routes the result back to the requesting port.

Parameters:
- NUM_PORTS, 2, number of requester channels (range 1..8).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- TIMEOUT, 0, cycles to wait for memory_response before aborting; 0 disables the timeout.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_PORTS  per-port request.
- req_write  in  NUM_PORTS  per-port write flag (1 = write, 0 = read).
- req_addr  in  NUM_PORTS*ADDR_WIDTH  per-port address; port i occupies slice i.
- req_wdata  in  NUM_PORTS*DATA_WIDTH  per-port write data.
- req_ready  out  NUM_PORTS  one-hot accept strobe; combinational.
- rsp_valid  out  NUM_PORTS  one-hot, single-cycle completion pulse.
- rsp_rdata  out  DATA_WIDTH  read data, valid while rsp_valid is nonzero.
- rsp_err  out  1  set together with rsp_valid when the transaction timed out.
- memory_addr  out  ADDR_WIDTH  memory address.
- memory_rden  out  1  memory read strobe.
- memory_wren  out  1  memory write strobe.
- memory_read_val  in  DATA_WIDTH  memory read data.
- memory_write_val  out  DATA_WIDTH  memory write data.
- memory_response  in  1  memory completion strobe.

Behaviour:
- Reset values: all outputs 0; state IDLE; rr_ptr 0; timeout counter 0. Reset in any state drops the in-flight transaction and no rsp_valid is produced for it.
- FSM has states IDLE, ACCESS and DONE.
- IDLE:
  - The winner is the first port i with req_valid[i]=1, searching from rr_ptr upward with wrap.
  - req_ready[winner]=1 combinationally, only in IDLE.
  - On that edge: latch addr, wdata, write and index; rr_ptr <= (winner+1) mod NUM_PORTS; go to ACCESS.
  - If no request is pending, stay in IDLE and hold rr_ptr.
- ACCESS:
  - Drive registered memory_addr/memory_write_val from the latched values.
  - memory_rden = !write and memory_wren = write, held high continuously.
  - On memory_response=1: capture memory_read_val (reads only; writes return 0 on rsp_rdata); drop both strobes on the next edge; go to DONE.
  - Timeout (only if TIMEOUT>0): the counter increments every ACCESS cycle without a response. On the cycle the counter reaches TIMEOUT-1 with no response, go to DONE with rsp_err=1 and rsp_rdata=0.
  - If a response and the timeout hit in the same cycle, the response wins.
- DONE: rsp_valid[index]=1 for exactly one cycle, then unconditionally return to IDLE.
- Latency:
  - Accept at edge 0 → strobes visible in cycle 1.
  - memory_response in cycle k → rsp_valid in cycle k+1 → next accept possible in cycle k+2.
  - Minimum request-to-request spacing is 3 cycles.
- memory_response is ignored outside ACCESS.
- Requesters must hold req_* stable while req_valid=1 until req_ready. Dropping req_valid before acceptance is legal; the request is simply not served.
- NUM_PORTS=1 degenerates to a pass-through with the same timing. rr_ptr stays 0.
- Write and read ports share no ordering beyond grant order.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state enum {IDLE, ACCESS, DONE};
  - the PORT_IDX_W = clog2(NUM_PORTS) helper;
  - default width constants.
- One sub-module, rr_picker. It is combinational: given req vector and rr_ptr, it returns a one-hot grant plus index and any_req.
- The FSM, latches and timeout counter stay in mem_port_arbiter.

Test Plan:
1. Single read: port0 reads 0x0000_0040; memory responds 2 cycles after the strobe with 0xDEADBEEF → exactly one rsp_valid=2'b01 pulse, rsp_rdata=0xDEADBEEF, rsp_err=0, rden high for exactly 3 cycles.
2. Write: port1 writes 0x1234_5678 to 0x100; response on the 1st strobe cycle → memory_wren=1, memory_write_val=0x12345678, memory_addr=0x100, rden=0, rsp_valid=2'b10.
3. Round-robin: both ports hold req_valid continuously with immediate responses → grants alternate 0,1,0,1 over 4 transactions, with no port starved.
4. Timeout: TIMEOUT=4 and memory_response held 0 → strobe drops after 4 ACCESS cycles, rsp_valid pulses with rsp_err=1 and rsp_rdata=0. A late memory_response while in IDLE is ignored.
5. Reset mid-ACCESS: assert reset during the 2nd ACCESS cycle → next cycle all outputs are 0, no rsp_valid ever appears for that transaction, and rr_ptr=0 so port0 wins the next grant.
6. Simultaneous response and timeout edge: TIMEOUT=3 with response on the 3rd ACCESS cycle → rsp_err=0 and rsp_rdata = memory_read_val.
